// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer between the shared I/D memory and
// the IF/ID register. It owns the fetch PC, keeps at most one read in flight,
// buffers up to DEPTH {inst, pc} entries and hands them to decode via
// valid/ready. A redirect flushes everything and restarts fetch. An EBREAK
// suspends fetch until the next redirect.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN. When it is defined, a response
// that arrives while the queue is empty is forwarded straight to decode.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 9,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_gnt,
  input  logic [31:0]            mem_rdata,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   deq_ready,
  output logic                   deq_valid,
  output logic [31:0]            deq_inst,
  output logic [31:0]            deq_pc,
  output logic [31:0]            deq_pc_4,
  output logic [$clog2(DEPTH):0] level,
  output logic                   halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0]  NOP_INST    = 32'h0000_0033;
  localparam logic [31:0]  EBREAK_INST = 32'h0010_0073;
  localparam logic [CNT_W:0] OCC_MAX   = (CNT_W+1)'(DEPTH);

  logic [31:0]      fetchPc_q, fetchPc_d;
  logic [31:0]      inflightPc_q, inflightPc_d;
  logic             inflight_q, inflight_d;
  logic             discard_q, discard_d;
  logic             halted_q, halted_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      instMem_q [DEPTH];
  logic [31:0]      pcMem_q   [DEPTH];

  logic grant;
  logic respValid;
  logic bypassOn;
  logic deqFire;
  logic wrEn;
  logic [CNT_W:0] occupancy;

  // Request/handshake qualifiers; a same-cycle dequeue earns no fetch credit
  always_comb begin
    occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    mem_req   = !rst && !halted_q && !redirect && (occupancy < OCC_MAX);
    mem_addr  = fetchPc_q[ADDR_W-1:0];
    grant     = mem_req && mem_gnt;
    respValid = inflight_q && !discard_q && !redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypassOn  = respValid && (count_q == '0);
`else
    bypassOn  = 1'b0;
`endif
    deqFire   = (count_q != '0) && deq_ready;
    wrEn      = respValid && !(bypassOn && deq_ready);
  end

  // Next-state for fetch PC, in-flight tracking, halt flag and queue pointers
  always_comb begin
    fetchPc_d    = fetchPc_q;
    inflightPc_d = inflightPc_q;
    inflight_d   = grant;
    discard_d    = 1'b0;
    halted_d     = halted_q;
    rdPtr_d      = rdPtr_q;
    wrPtr_d      = wrPtr_q;
    count_d      = count_q;
    if (redirect) begin
      fetchPc_d = redirect_pc & ~32'h3;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      count_d   = '0;
      halted_d  = 1'b0;
      discard_d = grant;
    end else begin
      if (grant) begin
        inflightPc_d = fetchPc_q;
        fetchPc_d    = fetchPc_q + 32'd4;
      end
      if (wrEn) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (deqFire) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      case ({wrEn, deqFire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (respValid && (mem_rdata == EBREAK_INST)) begin
        halted_d = 1'b1;
      end
    end
  end

  // Control state registers; reset also forgets any response still due
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc_q    <= RESET_PC;
      inflightPc_q <= '0;
      inflight_q   <= 1'b0;
      discard_q    <= 1'b0;
      halted_q     <= 1'b0;
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
      count_q      <= '0;
    end else begin
      fetchPc_q    <= fetchPc_d;
      inflightPc_q <= inflightPc_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
      halted_q     <= halted_d;
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
      count_q      <= count_d;
    end
  end

  // Queue storage: each accepted response is written at the write pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instMem_q[i] <= NOP_INST;
        pcMem_q[i]   <= '0;
      end
    end else if (wrEn) begin
      instMem_q[wrPtr_q] <= mem_rdata;
      pcMem_q[wrPtr_q]   <= inflightPc_q;
    end
  end

  // Decode-facing outputs: queue head, or the arriving word when bypassing
  always_comb begin
    deq_valid = (count_q != '0);
    deq_inst  = deq_valid ? instMem_q[rdPtr_q] : NOP_INST;
    deq_pc    = pcMem_q[rdPtr_q];
    if (bypassOn) begin
      deq_valid = 1'b1;
      deq_inst  = mem_rdata;
      deq_pc    = inflightPc_q;
    end
    deq_pc_4 = deq_pc + 32'd4;
    level    = count_q;
    halted   = halted_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a one-cycle-latency
// memory model. Streaming/backpressure is table driven; redirect, EBREAK,
// mid-operation reset and bypass are hand-written sequences.
module tb_fetch_queue;

  localparam int          DEPTH  = 4;
  localparam int          ADDR_W = 9;
  localparam int          LVL_W  = 3;
  localparam logic [31:0] NOP    = 32'h0000_0033;
  localparam logic [31:0] EBRK   = 32'h0010_0073;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt = 1'b0;
  logic [31:0]       mem_rdata;
  logic              redirect = 1'b0;
  logic [31:0]       redirect_pc = 32'h0;
  logic              deq_ready = 1'b0;
  logic              deq_valid;
  logic [31:0]       deq_inst;
  logic [31:0]       deq_pc;
  logic [31:0]       deq_pc_4;
  logic [LVL_W-1:0]  level;
  logic              halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_inst(deq_inst),
    .deq_pc(deq_pc), .deq_pc_4(deq_pc_4), .level(level), .halted(halted)
  );

  // Memory model: data for a granted address appears exactly one cycle later
  logic              respPending = 1'b0;
  logic [ADDR_W-1:0] respAddr = '0;
  logic              ebreakEn = 1'b0;
  logic [ADDR_W-1:0] ebreakAddr = 9'h008;

  always @(posedge clk) begin
    respPending <= mem_req && mem_gnt;
    respAddr    <= mem_addr;
  end

  assign mem_rdata = !respPending ? 32'hBAD0_BAD0 :
                     (ebreakEn && (respAddr == ebreakAddr)) ? EBRK :
                     (32'hC000_0000 | {23'h0, respAddr});

  function automatic logic [31:0] instAt(input logic [31:0] pc);
    return 32'hC000_0000 | pc;
  endfunction

  // Queue occupancy must never exceed DEPTH
  always @(negedge clk) begin
    if (!rst && (level > LVL_W'(DEPTH))) begin
      errors++;
      $display("[TB] FAIL overflow: level %0d exceeds %0d", level, DEPTH);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic gnt, input logic rdy, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    mem_gnt     = gnt;
    deq_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic checkCtl(input string tag, input logic req, input logic [ADDR_W-1:0] addr,
                          input logic [LVL_W-1:0] lvl, input logic hlt);
    checkOutput({tag, " mem_req"}, 32'(mem_req), 32'(req));
    checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'(addr));
    checkOutput({tag, " level"}, 32'(level), 32'(lvl));
    checkOutput({tag, " halted"}, 32'(halted), 32'(hlt));
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    checkOutput({tag, " deq_valid"}, 32'(deq_valid), 32'd1);
    checkOutput({tag, " deq_pc"}, deq_pc, pc);
    checkOutput({tag, " deq_pc_4"}, deq_pc_4, pc + 32'd4);
    checkOutput({tag, " deq_inst"}, deq_inst, inst);
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, " deq_valid"}, 32'(deq_valid), 32'd0);
    checkOutput({tag, " deq_inst"}, deq_inst, NOP);
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    mem_gnt = 1'b0; deq_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #1;
    checkCtl(tag, 1'b0, 9'h000, 3'd0, 1'b0);
    checkEmpty(tag);
    checkOutput({tag, " deq_pc"}, deq_pc, 32'h0);
    checkOutput({tag, " deq_pc_4"}, deq_pc_4, 32'h4);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  typedef struct {
    logic              gnt;
    logic              rdy;
    logic              expReq;
    logic [ADDR_W-1:0] expAddr;
    logic              expValid;
    logic [31:0]       expPc;
    logic [LVL_W-1:0]  expLevel;
  } vec_t;

  function automatic vec_t mkVec(input logic g, input logic r, input logic q, input logic [ADDR_W-1:0] a,
                                 input logic v, input logic [31:0] p, input logic [LVL_W-1:0] l);
    vec_t t;
    t.gnt = g; t.rdy = r; t.expReq = q; t.expAddr = a;
    t.expValid = v; t.expPc = p; t.expLevel = l;
    return t;
  endfunction

  vec_t tbl [15];

  initial begin
    // Streaming with full grants, then backpressure to full, then drain
    tbl[0]  = mkVec(1, 1, 1, 9'h000, 0, 32'h00, 3'd0);
    tbl[1]  = mkVec(1, 1, 1, 9'h004, 0, 32'h00, 3'd0);
    tbl[2]  = mkVec(1, 1, 1, 9'h008, 1, 32'h00, 3'd1);
    tbl[3]  = mkVec(1, 1, 1, 9'h00C, 1, 32'h04, 3'd1);
    tbl[4]  = mkVec(1, 0, 1, 9'h010, 1, 32'h08, 3'd1);
    tbl[5]  = mkVec(1, 0, 1, 9'h014, 1, 32'h08, 3'd2);
    tbl[6]  = mkVec(1, 0, 0, 9'h018, 1, 32'h08, 3'd3);
    tbl[7]  = mkVec(1, 0, 0, 9'h018, 1, 32'h08, 3'd4);
    tbl[8]  = mkVec(1, 0, 0, 9'h018, 1, 32'h08, 3'd4);
    tbl[9]  = mkVec(1, 1, 0, 9'h018, 1, 32'h08, 3'd4);
    tbl[10] = mkVec(1, 1, 1, 9'h018, 1, 32'h0C, 3'd3);
    tbl[11] = mkVec(1, 1, 1, 9'h01C, 1, 32'h10, 3'd2);
    tbl[12] = mkVec(1, 1, 1, 9'h020, 1, 32'h14, 3'd2);
    tbl[13] = mkVec(1, 1, 1, 9'h024, 1, 32'h18, 3'd2);
    tbl[14] = mkVec(1, 1, 1, 9'h028, 1, 32'h1C, 3'd2);

    doReset("reset0");

`ifndef FETCH_QUEUE_BYPASS_EN
    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].gnt, tbl[i].rdy, 1'b0, 32'h0);
      checkCtl($sformatf("stream%0d", i), tbl[i].expReq, tbl[i].expAddr, tbl[i].expLevel, 1'b0);
      if (tbl[i].expValid) checkHead($sformatf("stream%0d", i), tbl[i].expPc, instAt(tbl[i].expPc));
      else checkEmpty($sformatf("stream%0d", i));
    end
    doReset("reset1");
`endif

    // Redirect to 0x40 while the 0x10 response is arriving with level 2
    applyStimulus(1, 0, 1, 32'h8);  checkCtl("redir c0", 0, 9'h000, 3'd0, 0);
    applyStimulus(1, 0, 0, 32'h0);  checkCtl("redir c1", 1, 9'h008, 3'd0, 0);
    applyStimulus(1, 0, 0, 32'h0);  checkCtl("redir c2", 1, 9'h00C, 3'd0, 0);
    applyStimulus(1, 0, 0, 32'h0);  checkCtl("redir c3", 1, 9'h010, 3'd1, 0);
    applyStimulus(1, 0, 1, 32'h40); checkCtl("redir c4", 0, 9'h014, 3'd2, 0);
    checkHead("redir c4", 32'h8, instAt(32'h8));
    applyStimulus(1, 0, 0, 32'h0);  checkCtl("redir c5", 1, 9'h040, 3'd0, 0);
    checkEmpty("redir c5");
    applyStimulus(0, 0, 0, 32'h0);  checkCtl("redir c6", 1, 9'h044, 3'd0, 0);
    applyStimulus(0, 1, 0, 32'h0);  checkCtl("redir c7", 1, 9'h044, 3'd1, 0);
    checkHead("redir c7", 32'h40, instAt(32'h40));
    applyStimulus(0, 0, 0, 32'h0);  checkCtl("redir c8", 1, 9'h044, 3'd0, 0);
    checkEmpty("redir c8");

    // EBREAK at 0x8 halts fetch; redirect to 0x22 resumes at 0x20
    doReset("reset2");
    ebreakEn = 1'b1;
    applyStimulus(1, 0, 0, 32'h0);  checkCtl("ebrk c0", 1, 9'h000, 3'd0, 0);
    applyStimulus(1, 0, 0, 32'h0);  checkCtl("ebrk c1", 1, 9'h004, 3'd0, 0);
    applyStimulus(1, 0, 0, 32'h0);  checkCtl("ebrk c2", 1, 9'h008, 3'd1, 0);
    applyStimulus(0, 0, 0, 32'h0);  checkCtl("ebrk c3", 1, 9'h00C, 3'd2, 0);
    applyStimulus(1, 0, 0, 32'h0);  checkCtl("ebrk c4", 0, 9'h00C, 3'd3, 1);
    checkHead("ebrk c4", 32'h0, instAt(32'h0));
    applyStimulus(1, 1, 0, 32'h0);  checkCtl("ebrk c5", 0, 9'h00C, 3'd3, 1);
    checkHead("ebrk c5", 32'h0, instAt(32'h0));
    applyStimulus(1, 1, 0, 32'h0);  checkCtl("ebrk c6", 0, 9'h00C, 3'd2, 1);
    checkHead("ebrk c6", 32'h4, instAt(32'h4));
    applyStimulus(1, 1, 0, 32'h0);  checkCtl("ebrk c7", 0, 9'h00C, 3'd1, 1);
    checkHead("ebrk c7", 32'h8, EBRK);
    applyStimulus(1, 0, 1, 32'h22); checkCtl("ebrk c8", 0, 9'h00C, 3'd0, 1);
    checkEmpty("ebrk c8");
    applyStimulus(1, 0, 0, 32'h0);  checkCtl("ebrk c9", 1, 9'h020, 3'd0, 0);
    applyStimulus(0, 0, 0, 32'h0);  checkCtl("ebrk c10", 1, 9'h024, 3'd0, 0);
    applyStimulus(0, 0, 0, 32'h0);  checkCtl("ebrk c11", 1, 9'h024, 3'd1, 0);
    checkHead("ebrk c11", 32'h20, instAt(32'h20));
    ebreakEn = 1'b0;

    // Reset pulsed with level 3 and the 0xC response arriving
    doReset("reset3");
    applyStimulus(1, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0);  checkCtl("rstmid c3", 1, 9'h00C, 3'd2, 0);
    applyStimulus(0, 0, 0, 32'h0);  checkCtl("rstmid c4", 0, 9'h010, 3'd3, 0);
    doReset("rstmid assert");
    applyStimulus(1, 0, 0, 32'h0);  checkCtl("rstmid r0", 1, 9'h000, 3'd0, 0);
    applyStimulus(0, 0, 0, 32'h0);  checkCtl("rstmid r1", 1, 9'h004, 3'd0, 0);
    applyStimulus(0, 0, 0, 32'h0);  checkCtl("rstmid r2", 1, 9'h004, 3'd1, 0);
    checkHead("rstmid r2", 32'h0, instAt(32'h0));
    applyStimulus(0, 0, 0, 32'h0);  checkCtl("rstmid r3", 1, 9'h004, 3'd1, 0);

    // Single response into an empty queue with decode ready
    doReset("reset4");
    applyStimulus(1, 1, 0, 32'h0);  checkCtl("byp c0", 1, 9'h000, 3'd0, 0);
    applyStimulus(0, 1, 0, 32'h0);  checkCtl("byp c1", 1, 9'h004, 3'd0, 0);
    checkOutput("byp c1 deq_valid", 32'(deq_valid), 32'(BYP));
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("byp c2 deq_valid", 32'(deq_valid), 32'(!BYP));
    checkOutput("byp c2 level", 32'(level), BYP ? 32'd0 : 32'd1);
    applyStimulus(0, 1, 0, 32'h0);  checkCtl("byp c3", 1, 9'h004, 3'd0, 0);
    checkEmpty("byp c3");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch buffer between the shared single-ported instruction/data memory and the IF/ID pipeline register of the 5-stage RV32I core. It owns the fetch PC and issues word reads whenever the memory grants a fetch slot. It buffers up to DEPTH instructions with their PC and PC+4 and presents them to decode with a valid/ready handshake. It flushes and restarts on a branch/jump redirect from the MEM-stage branch unit, and stops fetching after an EBREAK until redirected.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- ADDR_W, 9, memory byte-address width driven on mem_addr
- RESET_PC, 32'h0, fetch PC after reset
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req  out  1  fetch read requested this cycle
- mem_addr  out  ADDR_W  byte address of the request, fetch_pc[ADDR_W-1:0]
- mem_gnt  in  1  memory accepted mem_req this cycle; ignored when mem_req=0
- mem_rdata  in  32  instruction word, valid exactly 1 cycle after the grant
- redirect  in  1  flush and restart fetch (branch unit pc_sel != 0)
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored, treated as 00
- deq_ready  in  1  decode accepts head entry (core drives ~stall)
- deq_valid  out  1  head entry valid
- deq_inst  out  32  head instruction; 32'h00000033 (add x0,x0,x0) when deq_valid=0
- deq_pc  out  32  PC of head instruction
- deq_pc_4  out  32  deq_pc + 4, mod 2^32
- level  out  $clog2(DEPTH)+1  entries currently held
- halted  out  1  EBREAK enqueued; fetch suspended

## Operation
- State: fetch_pc, circular buffer (inst, pc) with rd_ptr/wr_ptr/count, inflight flag + inflight_pc, discard flag, halted flag.
- mem_req = !rst && !halted && !redirect && (count + inflight < DEPTH). No credit taken for a same-cycle dequeue.
- On mem_req && mem_gnt: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps at 2^32).
- Response cycle (inflight=1): if discard=0, write {mem_rdata, inflight_pc} at wr_ptr; inflight clears unless a new grant occurs in the same cycle.
- EBREAK (32'h00100073) written into the queue sets halted. The EBREAK itself is still delivered to decode. No further mem_req until redirect.
- Dequeue when deq_valid && deq_ready: rd_ptr++, count--. Enqueue and dequeue in the same cycle leave count unchanged.
- Redirect (highest priority after rst): count<=0, pointers<=0, halted<=0, fetch_pc<={redirect_pc[31:2],2'b00}.
  - If a response is due next cycle or is arriving now, set discard so it is dropped.
  - deq_valid is 0 in the cycle after redirect. mem_req is 0 during the redirect cycle.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH; an overflow is a design error and is flagged by bench assertion.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC[ADDR_W-1:0], deq_valid=0, deq_inst=32'h00000033, deq_pc=0, deq_pc_4=4, level=0, halted=0. fetch_pc=RESET_PC; inflight, discard and pointers cleared.
- First mem_req is asserted in the first cycle after rst deasserts.
- Grant in cycle N: data sampled at the end of N+1. deq_valid rises in N+2 (N+1 with bypass, see Configuration).
- Sustained throughput: 1 instruction/cycle only while the memory grants every cycle. Max outstanding is 1.
- Redirect in cycle R: first new request is made in R+1; first new deq_valid in R+3 (R+2 with bypass).
- rst asserted mid-operation clears all state immediately, including a pending response. A response arriving after rst is ignored.
- deq_* are registered outputs (except under bypass). They are stable while deq_valid=1 and deq_ready=0.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count=0, a non-discarded response arriving this cycle drives deq_inst/deq_pc/deq_pc_4 combinationally from mem_rdata/inflight_pc, with deq_valid=1.
  - If deq_ready=1 the word is consumed and not written.
  - If deq_ready=0 the word is written normally.
- Not defined: every response is written first; deq_* come only from queue storage.

## Test plan
- Reset, RESET_PC=0, mem_gnt=1 always: mem_addr sequence 0,4,8,…; deq_pc 0,4,8 on consecutive cycles from cycle 2; deq_pc_4=deq_pc+4.
- deq_ready=0, mem_gnt=1, DEPTH=4: exactly 4 grants, then mem_req=0, level=4. Raise deq_ready → one dequeue per cycle, order preserved, mem_req resumes.
- Redirect to 0x40 in the same cycle as a response for PC 0x10 with level=2: 0x10 word never appears, level=0 next cycle, next deq_pc=0x40.
- Response returns 32'h00100073 at PC 0x8: halted=1, no mem_req after, EBREAK dequeued with deq_pc=0x8. Redirect 0x20 clears halted and fetches 0x20.
- rst pulsed while inflight=1 and level=3: all outputs at reset values on assertion; the late mem_rdata is not enqueued.
- With FETCH_QUEUE_BYPASS_EN, empty queue, deq_ready=1: deq_valid asserted in the response cycle and level stays 0. Without the macro, deq_valid is asserted one cycle later.
